serv_dbg_rf_shadow: RTL and testbench

//  Debug-side consumer of the RF write-snoop stream exported by serv_rf_top (dbg_rf_waddr/w1wren/we/wdata).

---
 rtl/serv_dbg_rf_shadow_if.sv | 11 +
 rtl/serv_dbg_rf_shadow.sv | 150 +++++++++++++++
 tb/tb_serv_dbg_rf_shadow.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/serv_dbg_rf_shadow_if.sv
// Debugger abstract-register read channel: req held until a one-cycle ack carrying data/valid.
interface serv_dbg_rf_shadow_if;
  logic        rd_req;
  logic [4:0]  rd_regno;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (output rd_req, rd_regno, input rd_ack, rd_data, rd_valid);
  modport slave  (input rd_req, rd_regno, output rd_ack, rd_data, rd_valid);
endinterface

// File: rtl/serv_dbg_rf_shadow.sv
// Shadow copy of x0..x31 rebuilt from the serv RF write-snoop stream; serves debugger reads
// with a 2-cycle ack, stalling a read only while that same register is mid-write.
module serv_dbg_rf_shadow #(
  parameter int RF_WIDTH = 8,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic [5:0]          i_dbg_rf_waddr,
  input  logic                i_dbg_rf_w1wren,
  input  logic                i_dbg_rf_we,
  input  logic [RF_WIDTH-1:0] i_dbg_rf_wdata,
  serv_dbg_rf_shadow_if.slave io_rd
);
  localparam int BEATS = 32 / RF_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  logic [BW-1:0]       r_bcnt;
  logic [31:0]         r_buf;
  logic [5:0]          r_idx;
  logic                r_cpend;
  logic [5:0]          r_cidx;
  logic [31:0]         r_cdata;
  logic [31:0]         r_shadow [NUM_REGS];
  logic [NUM_REGS-1:0] r_valid;
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ack;
  logic [31:0]         r_rd_data;
  logic                r_rd_valid;

  logic        w_beat;
  logic        w_first;
  logic        w_last;
  logic        w_drop;
  logic        w_commit;
  logic        w_conflict;
  logic [5:0]  w_cur_idx;
  logic [5:0]  w_rd_idx;
  logic [31:0] w_full;
  logic [31:0] w_rd_data;
  logic        w_rd_valid;

  assign w_beat    = i_dbg_rf_we & i_dbg_rf_w1wren;
  assign w_first   = w_beat & (r_bcnt == '0);
  assign w_last    = (r_bcnt == LAST);
  assign w_drop    = !i_dbg_rf_w1wren & (r_bcnt != '0);
  assign w_cur_idx = (r_bcnt == '0) ? i_dbg_rf_waddr : r_idx;
  assign w_rd_idx  = {1'b0, io_rd.rd_regno};
  assign w_commit  = r_cpend & (r_cidx != 6'd0) & (int'(r_cidx) < NUM_REGS);
  // A read must stall while its register is between beat 0 and the final beat.
  assign w_conflict = ((r_bcnt != '0) & (r_idx == w_rd_idx)) |
                      (w_first & (i_dbg_rf_waddr == w_rd_idx));

  always_comb begin
    w_full = r_buf;
    w_full[int'(r_bcnt) * RF_WIDTH +: RF_WIDTH] = i_dbg_rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_bcnt  <= '0;
      r_buf   <= '0;
      r_idx   <= '0;
      r_cpend <= 1'b0;
      r_cidx  <= '0;
      r_cdata <= '0;
    end else begin
      r_cpend <= w_beat & w_last;
      if (w_beat) begin
        r_buf <= w_full;
        if (w_first) r_idx <= i_dbg_rf_waddr;
        if (w_last) begin
          r_bcnt  <= '0;
          r_cidx  <= w_cur_idx;
          r_cdata <= w_full;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end else if (w_drop) begin
        r_bcnt <= '0;
        r_buf  <= '0;
      end
    end
  end

  // Storage is never cleared; r_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (w_commit) r_shadow[IW'(r_cidx)] <= r_cdata;
  end

  always_ff @(posedge clk) begin
    if (i_rst)         r_valid <= '0;
    else if (w_commit) r_valid[IW'(r_cidx)] <= 1'b1;
  end

  always_comb begin
    w_rd_data  = '0;
    w_rd_valid = 1'b0;
    if (io_rd.rd_regno == 5'd0) begin
      w_rd_valid = 1'b1;
    end else if (int'(io_rd.rd_regno) < NUM_REGS) begin
      if (w_commit & (r_cidx == w_rd_idx)) begin
        w_rd_data  = r_cdata;
        w_rd_valid = 1'b1;
      end else if (r_valid[IW'(io_rd.rd_regno)]) begin
        w_rd_data  = r_shadow[IW'(io_rd.rd_regno)];
        w_rd_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (io_rd.rd_req) w_state_nxt = w_conflict ? WAIT : RESP;
      WAIT:    if (!w_conflict) w_state_nxt = RESP;
      RESP:    w_state_nxt = DONE;
      DONE:    if (!io_rd.rd_req) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_ack      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_ack <= (r_state == RESP);
      if (r_state == RESP) begin
        r_rd_data  <= w_rd_data;
        r_rd_valid <= w_rd_valid;
      end
    end
  end

  assign io_rd.rd_ack   = r_ack;
  assign io_rd.rd_data  = r_rd_data;
  assign io_rd.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_serv_dbg_rf_shadow.sv
// Bench for serv_dbg_rf_shadow: fixed vectors, hand-built conflict/hold/reset sequences,
// then random snoop writes and reads checked against an array model of the GPR file.
module tb_serv_dbg_rf_shadow;
  localparam int RFW   = 8;
  localparam int BEATS = 32 / RFW;

  logic           clk = 1'b0;
  logic           rst;
  logic [5:0]     waddr;
  logic           w1wren;
  logic           we;
  logic [RFW-1:0] wdata;
  int             tests = 0;
  int             fails = 0;
  logic [31:0]    m_val [32];
  logic           m_vld [32];

  serv_dbg_rf_shadow_if rd_bus ();

  serv_dbg_rf_shadow #(.RF_WIDTH(RFW), .NUM_REGS(32)) dut (
    .clk             (clk),
    .i_rst           (rst),
    .i_dbg_rf_waddr  (waddr),
    .i_dbg_rf_w1wren (w1wren),
    .i_dbg_rf_we     (we),
    .i_dbg_rf_wdata  (wdata),
    .io_rd           (rd_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  waddr;
    logic [31:0] wval;
    int          nb;
    logic [4:0]  regno;
    logic [31:0] exp_d;
    logic        exp_v;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    waddr = '0; w1wren = 1'b0; we = 1'b0; wdata = '0;
    rd_bus.rd_req = 1'b0; rd_bus.rd_regno = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
  endtask

  task automatic snoop_write(input logic [5:0] a, input logic [31:0] v, input int nb, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        waddr = a; w1wren = 1'b1; we = 1'b0; @(negedge clk);
      end
      waddr = a; w1wren = 1'b1; we = 1'b1; wdata = v[b*RFW +: RFW];
      @(negedge clk);
    end
    w1wren = 1'b0; we = 1'b0;
    @(negedge clk);
    if (nb == BEATS && a != 6'd0 && a < 6'd32) begin
      m_val[a[4:0]] = v;
      m_vld[a[4:0]] = 1'b1;
    end
  endtask

  // elat > 0: exact ack latency required; elat == 0: ack must be later than the 2-cycle minimum.
  task automatic do_read(input logic [4:0] r, input logic [31:0] ed, input logic ev,
                         input int elat, input string nm);
    int lat;
    lat = 0;
    rd_bus.rd_req = 1'b1; rd_bus.rd_regno = r;
    do begin
      @(negedge clk);
      lat++;
    end while (!rd_bus.rd_ack && lat < 40);
    tests++;
    if (!rd_bus.rd_ack) begin
      fails++;
      $display("FAIL %s_ack: no ack after %0d cycles, ack required", nm, lat);
    end else begin
      if (elat > 0) chk({nm, "_lat"}, 32'(lat), 32'(elat));
      else          chk({nm, "_late"}, {31'd0, lat > 2}, 32'd1);
      chk({nm, "_data"}, rd_bus.rd_data, ed);
      chk({nm, "_valid"}, {31'd0, rd_bus.rd_valid}, {31'd0, ev});
    end
    rd_bus.rd_req = 1'b0;
    @(negedge clk);
    chk({nm, "_pulse"}, {31'd0, rd_bus.rd_ack}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acks;
    logic [4:0] rr;
    vt[0]  = '{6'd0,  32'h0000_0000, 0, 5'd5,  32'h0000_0000, 1'b0};
    vt[1]  = '{6'd0,  32'h0000_0000, 0, 5'd0,  32'h0000_0000, 1'b1};
    vt[2]  = '{6'd5,  32'h1234_5678, 4, 5'd5,  32'h1234_5678, 1'b1};
    vt[3]  = '{6'd1,  32'hA5A5_0001, 4, 5'd1,  32'hA5A5_0001, 1'b1};
    vt[4]  = '{6'd33, 32'hFFFF_FFFF, 4, 5'd1,  32'hA5A5_0001, 1'b1};
    vt[5]  = '{6'd0,  32'h1111_1111, 4, 5'd0,  32'h0000_0000, 1'b1};
    vt[6]  = '{6'd9,  32'hCAFE_F00D, 4, 5'd9,  32'hCAFE_F00D, 1'b1};
    vt[7]  = '{6'd9,  32'h0000_2211, 2, 5'd9,  32'hCAFE_F00D, 1'b1};
    vt[8]  = '{6'd9,  32'h0BAD_C0DE, 4, 5'd9,  32'h0BAD_C0DE, 1'b1};
    vt[9]  = '{6'd5,  32'h8765_4321, 4, 5'd5,  32'h8765_4321, 1'b1};
    vt[10] = '{6'd0,  32'h0000_0000, 0, 5'd31, 32'h0000_0000, 1'b0};

    do_reset();
    chk("rst_ack",   {31'd0, rd_bus.rd_ack},   32'd0);
    chk("rst_data",  rd_bus.rd_data,           32'd0);
    chk("rst_valid", {31'd0, rd_bus.rd_valid}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (vt[i].nb > 0) snoop_write(vt[i].waddr, vt[i].wval, vt[i].nb, 1'b0);
      do_read(vt[i].regno, vt[i].exp_d, vt[i].exp_v, 2, $sformatf("vec%0d", i));
    end

    // Read of x7 raised during beat 1 of its own write must wait for the commit.
    fork
      snoop_write(6'd7, 32'hDEAD_BEEF, 4, 1'b0);
      begin
        @(negedge clk);
        do_read(5'd7, 32'hDEAD_BEEF, 1'b1, 0, "x7_conflict");
      end
    join

    acks = 0;
    rd_bus.rd_req = 1'b1; rd_bus.rd_regno = 5'd5;
    repeat (10) begin
      @(negedge clk);
      if (rd_bus.rd_ack) acks++;
    end
    rd_bus.rd_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rd_bus.rd_ack) acks++;
    end
    chk("hold_one_ack", 32'(acks), 32'd1);
    chk("hold_data_kept", rd_bus.rd_data, 32'h8765_4321);

    repeat (80) begin
      if ($urandom_range(0, 3) < 2) begin
        snoop_write(6'($urandom_range(0, 40)), $urandom,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, BEATS - 1) : BEATS,
                    1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          waddr = 6'($urandom_range(0, 31)); we = 1'b1; w1wren = 1'b0; wdata = RFW'($urandom);
          @(negedge clk);
          we = 1'b0;
        end
      end else begin
        rr = 5'($urandom_range(0, 31));
        do_read(rr, (rr != 5'd0 && m_vld[rr]) ? m_val[rr] : 32'd0,
                (rr == 5'd0) ? 1'b1 : m_vld[rr], 2, $sformatf("rnd_x%0d", rr));
      end
    end

    // Reset while a read of x3 is parked in WAIT behind an unfinished x3 write.
    waddr = 6'd3; w1wren = 1'b1; we = 1'b1; wdata = 8'h11;
    @(negedge clk);
    wdata = 8'h22; rd_bus.rd_req = 1'b1; rd_bus.rd_regno = 5'd3;
    @(negedge clk);
    wdata = 8'h33;
    @(negedge clk);
    do_reset();
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (rd_bus.rd_ack) acks++;
    end
    chk("rst_wait_no_ack", 32'(acks), 32'd0);
    chk("rst_wait_data", rd_bus.rd_data, 32'd0);
    do_read(5'd3, 32'd0, 1'b0, 2, "post_rst_x3");
    do_read(5'd5, 32'd0, 1'b0, 2, "post_rst_x5");
    snoop_write(6'd3, 32'h0F1E_2D3C, 4, 1'b0);
    do_read(5'd3, 32'h0F1E_2D3C, 1'b1, 2, "post_rst_x3_wr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
